// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and FSM state encodings for the single-port RAM arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Contents:
//   ADDR_W / DATA_W  widths of the RAM address and data buses
//   addr_t / data_t  bus types used by the interface and the arbiter
//   arb_state_e      arbiter FSM states (IDLE, IF read in flight, MEM read in flight)
package ram_port_arbiter_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_RD_IF  = 2'd1,
    ARB_RD_MEM = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundles the pipeline-side (IF, MEM) and RAM-side signals of the RAM port arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req + payload until their response pulse (or IF kill).
//
// Port summary:
//   IF  : if_req, if_addr, if_kill        -> arbiter;  if_rvalid, if_rdata  <- arbiter
//   MEM : mem_req, mem_we, mem_addr,
//         mem_wdata, mem_wmask            -> arbiter;  mem_done, mem_rdata  <- arbiter
//   RAM : ram_rdata                       -> arbiter;  ram_ren, ram_raddr,
//                                                      ram_wen, ram_waddr,
//                                                      ram_wdata, ram_wmask <- arbiter
//   busy                                  <- arbiter (FSM not idle)
// Modports: slave = arbiter side, master = pipeline/RAM environment side.
interface ram_port_arbiter_if;
  import ram_port_arbiter_pkg::*;

  logic  if_req;
  addr_t if_addr;
  logic  if_kill;
  logic  if_rvalid;
  data_t if_rdata;

  logic  mem_req;
  logic  mem_we;
  addr_t mem_addr;
  data_t mem_wdata;
  data_t mem_wmask;
  logic  mem_done;
  data_t mem_rdata;

  logic  busy;

  logic  ram_ren;
  addr_t ram_raddr;
  data_t ram_rdata;
  logic  ram_wen;
  addr_t ram_waddr;
  data_t ram_wdata;
  data_t ram_wmask;

  modport slave (
    input  if_req, if_addr, if_kill,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  ram_rdata,
    output if_rvalid, if_rdata, mem_done, mem_rdata, busy,
    output ram_ren, ram_raddr, ram_wen, ram_waddr, ram_wdata, ram_wmask
  );

  modport master (
    output if_req, if_addr, if_kill,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output ram_rdata,
    input  if_rvalid, if_rdata, mem_done, mem_rdata, busy,
    input  ram_ren, ram_raddr, ram_wen, ram_waddr, ram_wdata, ram_wmask
  );

endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between IF (read-only) and MEM (load/store); fixed priority MEM > IF
// with an IF anti-starvation override. Latency: store done same cycle; reads respond RD_LAT
// cycles after issue, one read per RD_LAT+1 cycles. Backpressure: losers/busy-time requests wait.
//
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset; forces every output to 0 in the reset cycle
//   bus  - ram_port_arbiter_if.slave: IF/MEM request+response and RAM pins
module ram_port_arbiter #(
  parameter int RD_LAT    = 1,
  parameter int IF_STARVE = 4
) (
  input  logic                clk,
  input  logic                rst,
  ram_port_arbiter_if.slave   bus
);
  import ram_port_arbiter_pkg::*;

  localparam int LCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int SCW = $clog2(IF_STARVE + 1);

  arb_state_e     state_q;
  logic [LCW-1:0] lat_cnt_q;
  logic [SCW-1:0] starve_cnt_q;
  logic [SCW-1:0] starve_cnt_d;
  logic           kill_q;

  logic in_idle;
  logic if_ok;
  logic starve_hit;
  logic mem_win;
  logic if_win;
  logic resp;

  assign in_idle    = (state_q == ARB_IDLE);
  assign if_ok      = bus.if_req & ~bus.if_kill;
  // Once IF has lost IF_STARVE times in a row it takes the next IDLE slot from MEM.
  assign starve_hit = if_ok & (starve_cnt_q == SCW'(IF_STARVE));
  assign mem_win    = in_idle & bus.mem_req & ~starve_hit;
  assign if_win     = in_idle & if_ok & ~mem_win;
  // Response cycle: read in flight and the latency counter has run out.
  assign resp       = ~in_idle & (lat_cnt_q == '0);

  // IF loses only when MEM actually took the slot; any pause in IF demand resets the count.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.if_req || bus.if_kill || if_win) begin
      starve_cnt_d = '0;
    end else if (mem_win && !starve_hit) begin
      starve_cnt_d = starve_cnt_q + SCW'(1);
    end
  end

  // Issue and response strobes are combinational from registered state so a store
  // completes in its grant cycle; everything is forced low while rst is high.
  always_comb begin
    bus.if_rvalid = 1'b0;
    bus.if_rdata  = '0;
    bus.mem_done  = 1'b0;
    bus.mem_rdata = '0;
    bus.busy      = 1'b0;
    bus.ram_ren   = 1'b0;
    bus.ram_raddr = '0;
    bus.ram_wen   = 1'b0;
    bus.ram_waddr = '0;
    bus.ram_wdata = '0;
    bus.ram_wmask = '0;
    if (!rst) begin
      bus.busy = ~in_idle;
      if (mem_win) begin
        if (bus.mem_we) begin
          bus.ram_wen   = 1'b1;
          bus.ram_waddr = bus.mem_addr;
          bus.ram_wdata = bus.mem_wdata;
          bus.ram_wmask = bus.mem_wmask;
          bus.mem_done  = 1'b1;
        end else begin
          bus.ram_ren   = 1'b1;
          bus.ram_raddr = bus.mem_addr;
        end
      end else if (if_win) begin
        bus.ram_ren   = 1'b1;
        bus.ram_raddr = bus.if_addr;
      end
      if (resp && state_q == ARB_RD_MEM) begin
        bus.mem_done  = 1'b1;
        bus.mem_rdata = bus.ram_rdata;
      end
      // A kill landing in the response cycle itself must also swallow the data.
      if (resp && state_q == ARB_RD_IF && !kill_q && !bus.if_kill) begin
        bus.if_rvalid = 1'b1;
        bus.if_rdata  = bus.ram_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      kill_q       <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      case (state_q)
        ARB_IDLE: begin
          kill_q <= 1'b0;
          if (mem_win && !bus.mem_we) begin
            state_q   <= ARB_RD_MEM;
            lat_cnt_q <= LCW'(RD_LAT - 1);
          end else if (if_win) begin
            state_q   <= ARB_RD_IF;
            lat_cnt_q <= LCW'(RD_LAT - 1);
          end
        end
        ARB_RD_IF, ARB_RD_MEM: begin
          if (lat_cnt_q == '0) begin
            state_q <= ARB_IDLE;
            kill_q  <= 1'b0;
          end else begin
            lat_cnt_q <= lat_cnt_q - LCW'(1);
            if (state_q == ARB_RD_IF && bus.if_kill) begin
              kill_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q   <= ARB_IDLE;
          lat_cnt_q <= '0;
          kill_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: one instance with RD_LAT=1 and one with RD_LAT=3 share the
// same stimulus; every cycle both are compared with a transaction-level reference model,
// and the directed scenarios add explicit expectations on top.
module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;

  localparam int IF_STARVE = 4;

  typedef struct packed {
    logic        rv, done, busy, ren, wen;
    logic [63:0] ird, mrd, raddr, waddr, wdata, wmask;
  } outs_t;

  logic        clk, rst;
  logic        if_req, if_kill, mem_req, mem_we;
  logic [63:0] if_addr, mem_addr, mem_wdata, mem_wmask, ram_rdata;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: one outstanding read per instance, tracked by who owns it and the
  // absolute cycle at which its data is due.
  int lat[2] = '{1, 3};
  bit pend[2], pend_n[2];
  bit who_if[2], who_if_n[2];
  bit killed[2], killed_n[2];
  int due[2], due_n[2];
  int starve[2], starve_n[2];

  outs_t o1, o3, e0, e1;

  ram_port_arbiter_if b1 ();
  ram_port_arbiter_if b3 ();

  ram_port_arbiter #(.RD_LAT(1), .IF_STARVE(IF_STARVE)) u_l1 (.clk(clk), .rst(rst), .bus(b1.slave));
  ram_port_arbiter #(.RD_LAT(3), .IF_STARVE(IF_STARVE)) u_l3 (.clk(clk), .rst(rst), .bus(b3.slave));

  assign b1.if_req    = if_req;     assign b3.if_req    = if_req;
  assign b1.if_addr   = if_addr;    assign b3.if_addr   = if_addr;
  assign b1.if_kill   = if_kill;    assign b3.if_kill   = if_kill;
  assign b1.mem_req   = mem_req;    assign b3.mem_req   = mem_req;
  assign b1.mem_we    = mem_we;     assign b3.mem_we    = mem_we;
  assign b1.mem_addr  = mem_addr;   assign b3.mem_addr  = mem_addr;
  assign b1.mem_wdata = mem_wdata;  assign b3.mem_wdata = mem_wdata;
  assign b1.mem_wmask = mem_wmask;  assign b3.mem_wmask = mem_wmask;
  assign b1.ram_rdata = ram_rdata;  assign b3.ram_rdata = ram_rdata;

  assign o1 = {b1.if_rvalid, b1.mem_done, b1.busy, b1.ram_ren, b1.ram_wen, b1.if_rdata,
               b1.mem_rdata, b1.ram_raddr, b1.ram_waddr, b1.ram_wdata, b1.ram_wmask};
  assign o3 = {b3.if_rvalid, b3.mem_done, b3.busy, b3.ram_ren, b3.ram_wen, b3.if_rdata,
               b3.mem_rdata, b3.ram_raddr, b3.ram_waddr, b3.ram_wdata, b3.ram_wmask};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs of instance k for the current inputs; next model state goes to *_n.
  task automatic model(input int k, output outs_t e);
    bit ifc;
    e = '0;
    pend_n[k] = pend[k]; who_if_n[k] = who_if[k]; killed_n[k] = killed[k];
    due_n[k] = due[k];   starve_n[k] = starve[k];
    ifc = if_req && !if_kill;
    if (rst) begin
      pend_n[k] = 1'b0; killed_n[k] = 1'b0; starve_n[k] = 0;
    end else if (pend[k]) begin
      e.busy = 1'b1;
      if (cyc == due[k]) begin
        if (!who_if[k]) begin
          e.done = 1'b1; e.mrd = ram_rdata;
        end else if (!killed[k] && !if_kill) begin
          e.rv = 1'b1; e.ird = ram_rdata;
        end
        pend_n[k] = 1'b0; killed_n[k] = 1'b0;
      end else if (who_if[k] && if_kill) begin
        killed_n[k] = 1'b1;
      end
      if (!ifc) starve_n[k] = 0;
    end else if (mem_req && !(ifc && starve[k] == IF_STARVE)) begin
      if (mem_we) begin
        e.wen = 1'b1; e.done = 1'b1;
        e.waddr = mem_addr; e.wdata = mem_wdata; e.wmask = mem_wmask;
      end else begin
        e.ren = 1'b1; e.raddr = mem_addr;
        pend_n[k] = 1'b1; who_if_n[k] = 1'b0; due_n[k] = cyc + lat[k];
      end
      starve_n[k] = ifc ? ((starve[k] < IF_STARVE) ? starve[k] + 1 : IF_STARVE) : 0;
    end else if (ifc) begin
      e.ren = 1'b1; e.raddr = if_addr;
      pend_n[k] = 1'b1; who_if_n[k] = 1'b1; due_n[k] = cyc + lat[k];
      starve_n[k] = 0;
    end else begin
      starve_n[k] = 0;
    end
  endtask

  task automatic cmp(input string t, input outs_t o, input outs_t e);
    chk({t, ".ctrl"},  {o.rv, o.done, o.busy, o.ren, o.wen}, {e.rv, e.done, e.busy, e.ren, e.wen});
    chk({t, ".ird"},   o.ird,   e.ird);
    chk({t, ".mrd"},   o.mrd,   e.mrd);
    chk({t, ".raddr"}, o.raddr, e.raddr);
    chk({t, ".waddr"}, o.waddr, e.waddr);
    chk({t, ".wdata"}, o.wdata, e.wdata);
    chk({t, ".wmask"}, o.wmask, e.wmask);
  endtask

  // Sample away from the active edge and compare both instances against the model.
  task automatic look();
    @(negedge clk);
    model(0, e0);
    model(1, e1);
    cmp("lat1", o1, e0);
    cmp("lat3", o3, e1);
  endtask

  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      pend[k] = pend_n[k]; who_if[k] = who_if_n[k]; killed[k] = killed_n[k];
      due[k] = due_n[k];   starve[k] = starve_n[k];
    end
    cyc++;
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      look();
      step();
    end
  endtask

  task automatic quiet();
    if_req = 1'b0; if_kill = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      pend[k] = 1'b0; who_if[k] = 1'b0; killed[k] = 1'b0; due[k] = 0; starve[k] = 0;
    end
    // Reset with live requests: every output must stay low.
    rst = 1'b1; if_req = 1'b1; if_kill = 1'b0; mem_req = 1'b1; mem_we = 1'b1;
    if_addr = 64'h8000_0000; mem_addr = 64'h8000_0300;
    mem_wdata = 64'hFFFF_FFFF_FFFF_FFFF; mem_wmask = 64'hFFFF_FFFF_FFFF_FFFF;
    ram_rdata = 64'h5555_AAAA_5555_AAAA;
    look();
    chk("rst.ctrl1", {o1.rv, o1.done, o1.busy, o1.ren, o1.wen}, 5'b0);
    chk("rst.ctrl3", {o3.rv, o3.done, o3.busy, o3.ren, o3.wen}, 5'b0);
    chk("rst.wdata", o1.wdata, 64'h0);
    step();
    cycles(1);
    rst = 1'b0; quiet();
    cycles(2);

    // IF alone, RD_LAT=1.
    if_req = 1'b1; if_addr = 64'h8000_0000; ram_rdata = 64'h1111_2222_3333_4444;
    look();
    chk("if.issue_ren", o1.ren, 1'b1);
    chk("if.issue_addr", o1.raddr, 64'h8000_0000);
    step();
    look();
    chk("if.rvalid", o1.rv, 1'b1);
    chk("if.rdata", o1.ird, 64'h1111_2222_3333_4444);
    chk("if.no_reissue", o1.ren, 1'b0);
    step();
    quiet();
    cycles(4);

    // Simultaneous IF and MEM load: MEM first.
    if_req = 1'b1; if_addr = 64'h8000_0040;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h8000_0100; ram_rdata = 64'hAAAA_0000_0000_0001;
    look();
    chk("sim.mem_first", o1.raddr, 64'h8000_0100);
    step();
    look();
    chk("sim.mem_done", {o1.done, o1.rv}, 2'b10);
    chk("sim.mem_rdata", o1.mrd, 64'hAAAA_0000_0000_0001);
    step();
    mem_req = 1'b0; ram_rdata = 64'hBBBB_0000_0000_0002;
    look();
    chk("sim.if_issue", {o1.ren, o1.raddr}, {1'b1, 64'h8000_0040});
    step();
    ram_rdata = 64'hCCCC_0000_0000_0003;
    look();
    chk("sim.if_rdata", {o1.rv, o1.ird}, {1'b1, 64'hCCCC_0000_0000_0003});
    step();
    quiet();
    cycles(5);

    // Store: completes in the grant cycle, never busy.
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 64'h8000_0200;
    mem_wdata = 64'hDEAD_BEEF; mem_wmask = 64'hFFFF_FFFF;
    look();
    chk("st.ctrl", {o1.done, o1.busy, o1.ren, o1.wen}, 4'b1001);
    chk("st.wdata", o1.wdata, 64'hDEAD_BEEF);
    chk("st.wmask", o3.wmask, 64'hFFFF_FFFF);
    step();
    quiet();
    cycles(1);

    // Starvation: IF loses exactly IF_STARVE slots to back-to-back stores, then wins.
    mem_req = 1'b1; mem_we = 1'b1; if_req = 1'b1; if_addr = 64'h8000_1000;
    for (int i = 0; i < IF_STARVE; i++) begin
      look();
      chk("stv.lose", {o1.ren, o1.wen}, 2'b01);
      step();
    end
    look();
    chk("stv.win", {o1.ren, o1.wen, o1.raddr}, {2'b10, 64'h8000_1000});
    step();
    ram_rdata = 64'h0123_4567_89AB_CDEF;
    look();
    chk("stv.rvalid", o1.rv, 1'b1);
    step();
    if_req = 1'b0;
    look();
    chk("stv.mem_back", o1.wen, 1'b1);
    step();
    quiet();
    cycles(4);

    // Kill during RD_IF on the RD_LAT=3 instance (kill lands in lat1's response cycle).
    if_req = 1'b1; if_addr = 64'h8000_2000; ram_rdata = 64'h7777_7777_7777_7777;
    look();
    chk("kill.issue", o3.ren, 1'b1);
    step();
    if_kill = 1'b1;
    look();
    chk("kill.resp_cycle_l1", {o1.rv, o1.busy}, 2'b01);
    step();
    quiet();
    cycles(1);
    look();
    chk("kill.no_rvalid", {o3.rv, o3.busy}, 2'b01);
    step();
    look();
    chk("kill.idle_t4", o3.busy, 1'b0);
    step();
    cycles(2);

    // Kill in the RD_LAT=3 response cycle.
    if_req = 1'b1; if_addr = 64'h8000_3000;
    cycles(3);
    if_kill = 1'b1;
    look();
    chk("killr.no_rvalid", {o3.rv, o3.busy}, 2'b01);
    step();
    quiet();
    look();
    chk("killr.idle", o3.busy, 1'b0);
    step();
    cycles(3);

    // Reset while RD_MEM is in flight on the RD_LAT=3 instance.
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h8000_4000; ram_rdata = 64'h9999_0000_9999_0000;
    look();
    chk("rstrd.issue", o3.ren, 1'b1);
    step();
    cycles(1);
    rst = 1'b1;
    look();
    chk("rstrd.in_rst", {o3.done, o3.busy, o3.ren, o3.mrd}, 67'h0);
    step();
    rst = 1'b0; quiet();
    look();
    chk("rstrd.after", {o3.done, o3.busy, o3.ren, o3.wen}, 4'b0);
    step();
    mem_req = 1'b1; mem_addr = 64'h8000_5000; ram_rdata = 64'h4242_4242_4242_4242;
    look();
    chk("rstrd.reissue", {o3.ren, o3.raddr}, {1'b1, 64'h8000_5000});
    step();
    cycles(2);
    look();
    chk("rstrd.done", {o3.done, o3.mrd}, {1'b1, 64'h4242_4242_4242_4242});
    step();
    quiet();
    cycles(4);

    // Random traffic, including occasional kills and resets.
    for (int i = 0; i < 2000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      if_req    = ($urandom_range(0, 3) != 0);
      if_kill   = ($urandom_range(0, 7) == 0);
      mem_req   = $urandom_range(0, 1) == 1;
      mem_we    = $urandom_range(0, 1) == 1;
      if_addr   = {$urandom, $urandom};
      mem_addr  = {$urandom, $urandom};
      mem_wdata = {$urandom, $urandom};
      mem_wmask = {$urandom, $urandom};
      ram_rdata = {$urandom, $urandom};
      look();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
